// File: rtl/modport_bridge_if.sv
// AXI4 bundle shared by both sides of the bridge; master drives requests, slave drives responses.
interface axi_channel #(
  parameter int ID_WIDTH      = 8,
  parameter int ADDR_WIDTH    = 48,
  parameter int DATA_WIDTH    = 64,
  parameter int AW_USER_WIDTH = 1,
  parameter int AR_USER_WIDTH = 1,
  parameter int W_USER_WIDTH  = 1,
  parameter int R_USER_WIDTH  = 1,
  parameter int B_USER_WIDTH  = 1
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ID_WIDTH-1:0]      aw_id;
  logic [ADDR_WIDTH-1:0]    aw_addr;
  logic [7:0]               aw_len;
  logic [2:0]               aw_size;
  logic [1:0]               aw_burst;
  logic                     aw_lock;
  logic [3:0]               aw_cache;
  logic [2:0]               aw_prot;
  logic [3:0]               aw_qos;
  logic [3:0]               aw_region;
  logic [AW_USER_WIDTH-1:0] aw_user;
  logic                     aw_valid;
  logic                     aw_ready;

  logic [ID_WIDTH-1:0]      ar_id;
  logic [ADDR_WIDTH-1:0]    ar_addr;
  logic [7:0]               ar_len;
  logic [2:0]               ar_size;
  logic [1:0]               ar_burst;
  logic                     ar_lock;
  logic [3:0]               ar_cache;
  logic [2:0]               ar_prot;
  logic [3:0]               ar_qos;
  logic [3:0]               ar_region;
  logic [AR_USER_WIDTH-1:0] ar_user;
  logic                     ar_valid;
  logic                     ar_ready;

  logic [DATA_WIDTH-1:0]    w_data;
  logic [STRB_WIDTH-1:0]    w_strb;
  logic                     w_last;
  logic [W_USER_WIDTH-1:0]  w_user;
  logic                     w_valid;
  logic                     w_ready;

  logic [ID_WIDTH-1:0]      r_id;
  logic [DATA_WIDTH-1:0]    r_data;
  logic [1:0]               r_resp;
  logic                     r_last;
  logic [R_USER_WIDTH-1:0]  r_user;
  logic                     r_valid;
  logic                     r_ready;

  logic [ID_WIDTH-1:0]      b_id;
  logic [1:0]               b_resp;
  logic [B_USER_WIDTH-1:0]  b_user;
  logic                     b_valid;
  logic                     b_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
           aw_region, aw_user, aw_valid,
    input  aw_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
           ar_region, ar_user, ar_valid,
    input  ar_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
           aw_region, aw_user, aw_valid,
    output aw_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
           ar_region, ar_user, ar_valid,
    output ar_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready
  );
endinterface

// File: rtl/modport_bridge.sv
// AXI4 register bridge: one 2-entry skid slice per channel, 1-cycle latency, full throughput.
// Input ready comes straight from a flop and drops only while the skid entry holds a stalled beat.
module skid_slice #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat
);
  logic             main_vld_q, main_vld_d;
  logic             skid_vld_q, skid_vld_d;
  logic             rdy_q, rdy_d;
  logic [WIDTH-1:0] main_dat_q, main_dat_d;
  logic [WIDTH-1:0] skid_dat_q, skid_dat_d;
  logic             in_fire;
  logic             main_free;

  always_comb begin
    in_fire    = in_vld & rdy_q;
    main_free  = ~main_vld_q | out_rdy;
    main_vld_d = main_vld_q;
    main_dat_d = main_dat_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    if (main_free) begin
      // rdy_q is low whenever skid holds a beat, so skid drain and in_fire never coincide
      if (skid_vld_q) begin
        main_vld_d = 1'b1;
        main_dat_d = skid_dat_q;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = in_fire;
        if (in_fire) main_dat_d = in_dat;
      end
    end else if (in_fire) begin
      skid_vld_d = 1'b1;
      skid_dat_d = in_dat;
    end
    rdy_d = ~skid_vld_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= rdy_d;
    end
  end

  always_ff @(posedge clk) begin
    main_dat_q <= main_dat_d;
    skid_dat_q <= skid_dat_d;
  end

  assign in_rdy  = rdy_q;
  assign out_vld = main_vld_q;
  assign out_dat = main_dat_q;
endmodule

module modport_bridge #(
  parameter int ID_WIDTH      = 8,
  parameter int ADDR_WIDTH    = 48,
  parameter int DATA_WIDTH    = 64,
  parameter int AW_USER_WIDTH = 1,
  parameter int AR_USER_WIDTH = 1,
  parameter int W_USER_WIDTH  = 1,
  parameter int R_USER_WIDTH  = 1,
  parameter int B_USER_WIDTH  = 1
) (
  input logic        clk,
  input logic        rstn,
  axi_channel.slave  upstream,
  axi_channel.master downstream
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int AW_W = ID_WIDTH + ADDR_WIDTH + 29 + AW_USER_WIDTH;
  localparam int AR_W = ID_WIDTH + ADDR_WIDTH + 29 + AR_USER_WIDTH;
  localparam int W_W  = DATA_WIDTH + STRB_WIDTH + 1 + W_USER_WIDTH;
  localparam int R_W  = ID_WIDTH + DATA_WIDTH + 3 + R_USER_WIDTH;
  localparam int B_W  = ID_WIDTH + 2 + B_USER_WIDTH;

  if (DATA_WIDTH < 8 || DATA_WIDTH > 1024 || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0) begin : g_bad_width
    $fatal(1, "modport_bridge: DATA_WIDTH must be a power of 2 within [8,1024]");
  end

  logic [AW_W-1:0] aw_in, aw_out;
  logic [AR_W-1:0] ar_in, ar_out;
  logic [W_W-1:0]  w_in, w_out;
  logic [R_W-1:0]  r_in, r_out;
  logic [B_W-1:0]  b_in, b_out;

  assign aw_in = {upstream.aw_id, upstream.aw_addr, upstream.aw_len, upstream.aw_size,
                  upstream.aw_burst, upstream.aw_lock, upstream.aw_cache, upstream.aw_prot,
                  upstream.aw_qos, upstream.aw_region, upstream.aw_user};
  assign {downstream.aw_id, downstream.aw_addr, downstream.aw_len, downstream.aw_size,
          downstream.aw_burst, downstream.aw_lock, downstream.aw_cache, downstream.aw_prot,
          downstream.aw_qos, downstream.aw_region, downstream.aw_user} = aw_out;

  assign ar_in = {upstream.ar_id, upstream.ar_addr, upstream.ar_len, upstream.ar_size,
                  upstream.ar_burst, upstream.ar_lock, upstream.ar_cache, upstream.ar_prot,
                  upstream.ar_qos, upstream.ar_region, upstream.ar_user};
  assign {downstream.ar_id, downstream.ar_addr, downstream.ar_len, downstream.ar_size,
          downstream.ar_burst, downstream.ar_lock, downstream.ar_cache, downstream.ar_prot,
          downstream.ar_qos, downstream.ar_region, downstream.ar_user} = ar_out;

  assign w_in = {upstream.w_data, upstream.w_strb, upstream.w_last, upstream.w_user};
  assign {downstream.w_data, downstream.w_strb, downstream.w_last, downstream.w_user} = w_out;

  assign r_in = {downstream.r_id, downstream.r_data, downstream.r_resp, downstream.r_last,
                 downstream.r_user};
  assign {upstream.r_id, upstream.r_data, upstream.r_resp, upstream.r_last, upstream.r_user} = r_out;

  assign b_in = {downstream.b_id, downstream.b_resp, downstream.b_user};
  assign {upstream.b_id, upstream.b_resp, upstream.b_user} = b_out;

  skid_slice #(.WIDTH(AW_W)) u_aw (
    .clk(clk), .rstn(rstn),
    .in_vld(upstream.aw_valid), .in_rdy(upstream.aw_ready), .in_dat(aw_in),
    .out_vld(downstream.aw_valid), .out_rdy(downstream.aw_ready), .out_dat(aw_out)
  );

  skid_slice #(.WIDTH(AR_W)) u_ar (
    .clk(clk), .rstn(rstn),
    .in_vld(upstream.ar_valid), .in_rdy(upstream.ar_ready), .in_dat(ar_in),
    .out_vld(downstream.ar_valid), .out_rdy(downstream.ar_ready), .out_dat(ar_out)
  );

  skid_slice #(.WIDTH(W_W)) u_w (
    .clk(clk), .rstn(rstn),
    .in_vld(upstream.w_valid), .in_rdy(upstream.w_ready), .in_dat(w_in),
    .out_vld(downstream.w_valid), .out_rdy(downstream.w_ready), .out_dat(w_out)
  );

  skid_slice #(.WIDTH(R_W)) u_r (
    .clk(clk), .rstn(rstn),
    .in_vld(downstream.r_valid), .in_rdy(downstream.r_ready), .in_dat(r_in),
    .out_vld(upstream.r_valid), .out_rdy(upstream.r_ready), .out_dat(r_out)
  );

  skid_slice #(.WIDTH(B_W)) u_b (
    .clk(clk), .rstn(rstn),
    .in_vld(downstream.b_valid), .in_rdy(downstream.b_ready), .in_dat(b_in),
    .out_vld(upstream.b_valid), .out_rdy(upstream.b_ready), .out_dat(b_out)
  );
endmodule

// File: tb/tb_modport_bridge.sv
// Directed bench for modport_bridge: inputs change and outputs are sampled on the falling edge.
module tb_modport_bridge;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  axi_channel up_if ();
  axi_channel dn_if ();

  modport_bridge dut (
    .clk(clk),
    .rstn(rstn),
    .upstream(up_if),
    .downstream(dn_if)
  );

  task automatic idle();
    up_if.aw_valid = 0; up_if.aw_id = '0; up_if.aw_addr = '0; up_if.aw_len = '0;
    up_if.aw_size = '0; up_if.aw_burst = '0; up_if.aw_lock = 0; up_if.aw_cache = '0;
    up_if.aw_prot = '0; up_if.aw_qos = '0; up_if.aw_region = '0; up_if.aw_user = '0;
    up_if.ar_valid = 0; up_if.ar_id = '0; up_if.ar_addr = '0; up_if.ar_len = '0;
    up_if.ar_size = '0; up_if.ar_burst = '0; up_if.ar_lock = 0; up_if.ar_cache = '0;
    up_if.ar_prot = '0; up_if.ar_qos = '0; up_if.ar_region = '0; up_if.ar_user = '0;
    up_if.w_valid = 0; up_if.w_data = '0; up_if.w_strb = '0; up_if.w_last = 0; up_if.w_user = '0;
    up_if.r_ready = 1; up_if.b_ready = 1;
    dn_if.aw_ready = 1; dn_if.ar_ready = 1; dn_if.w_ready = 1;
    dn_if.r_valid = 0; dn_if.r_id = '0; dn_if.r_data = '0; dn_if.r_resp = '0;
    dn_if.r_last = 0; dn_if.r_user = '0;
    dn_if.b_valid = 0; dn_if.b_id = '0; dn_if.b_resp = '0; dn_if.b_user = '0;
  endtask

  task automatic test_reset();
    logic [4:0] v, r;
    rstn = 0;
    idle();
    repeat (2) @(negedge clk);
    v = {dn_if.aw_valid, dn_if.ar_valid, dn_if.w_valid, up_if.r_valid, up_if.b_valid};
    r = {up_if.aw_ready, up_if.ar_ready, up_if.w_ready, dn_if.r_ready, dn_if.b_ready};
    checks++; if (v !== 5'b0) begin failures++; $display("FAIL reset_valids got=%b exp=00000", v); end
    checks++; if (r !== 5'b0) begin failures++; $display("FAIL reset_readies got=%b exp=00000", r); end
    rstn = 1;
    #1;
    r = {up_if.aw_ready, up_if.ar_ready, up_if.w_ready, dn_if.r_ready, dn_if.b_ready};
    checks++; if (r !== 5'b0) begin failures++; $display("FAIL release_no_edge_readies got=%b exp=00000", r); end
    @(negedge clk);
    r = {up_if.aw_ready, up_if.ar_ready, up_if.w_ready, dn_if.r_ready, dn_if.b_ready};
    v = {dn_if.aw_valid, dn_if.ar_valid, dn_if.w_valid, up_if.r_valid, up_if.b_valid};
    checks++; if (r !== 5'b11111) begin failures++; $display("FAIL release_readies got=%b exp=11111", r); end
    checks++; if (v !== 5'b0) begin failures++; $display("FAIL release_valids got=%b exp=00000", v); end
  endtask

  task automatic test_single_aw();
    logic [93:0] got;
    logic [93:0] exp;
    exp = {8'h5A, 48'h0000_1234_5678, 8'd3, 3'd3, 2'b01, 1'b0, 4'h3, 3'h2, 4'h5, 4'h1, 1'b1};
    @(negedge clk);
    idle();
    up_if.aw_id = 8'h5A; up_if.aw_addr = 48'h0000_1234_5678; up_if.aw_len = 8'd3;
    up_if.aw_size = 3'd3; up_if.aw_burst = 2'b01; up_if.aw_lock = 0; up_if.aw_cache = 4'h3;
    up_if.aw_prot = 3'h2; up_if.aw_qos = 4'h5; up_if.aw_region = 4'h1; up_if.aw_user = 1'b1;
    up_if.aw_valid = 1;
    checks++; if (dn_if.aw_valid !== 0) begin failures++; $display("FAIL aw_early got=%b exp=0", dn_if.aw_valid); end
    @(negedge clk);
    up_if.aw_valid = 0;
    got = {dn_if.aw_id, dn_if.aw_addr, dn_if.aw_len, dn_if.aw_size, dn_if.aw_burst, dn_if.aw_lock,
           dn_if.aw_cache, dn_if.aw_prot, dn_if.aw_qos, dn_if.aw_region, dn_if.aw_user};
    checks++; if (dn_if.aw_valid !== 1) begin failures++; $display("FAIL aw_valid got=%b exp=1", dn_if.aw_valid); end
    checks++; if (got !== exp) begin failures++; $display("FAIL aw_fields got=%h exp=%h", got, exp); end
    @(negedge clk);
    checks++; if (dn_if.aw_valid !== 0) begin failures++; $display("FAIL aw_one_cycle got=%b exp=0", dn_if.aw_valid); end
  endtask

  task automatic test_w_burst();
    @(negedge clk);
    idle();
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      if (i >= 1 && i <= 4) begin
        checks++;
        if (dn_if.w_valid !== 1 || dn_if.w_data !== 64'(i) || dn_if.w_strb !== 8'hFF ||
            dn_if.w_last !== (i == 4) || dn_if.w_user !== 1'(i - 1)) begin
          failures++;
          $display("FAIL w_burst_beat%0d got v=%b d=%h s=%h l=%b u=%b exp v=1 d=%h s=ff l=%b u=%b",
                   i, dn_if.w_valid, dn_if.w_data, dn_if.w_strb, dn_if.w_last, dn_if.w_user,
                   64'(i), (i == 4), 1'(i - 1));
        end
      end else begin
        checks++; if (dn_if.w_valid !== 0) begin failures++; $display("FAIL w_burst_idle%0d got=%b exp=0", i, dn_if.w_valid); end
      end
      if (i < 4) begin
        checks++; if (up_if.w_ready !== 1) begin failures++; $display("FAIL w_burst_ready%0d got=%b exp=1", i, up_if.w_ready); end
        up_if.w_valid = 1; up_if.w_data = 64'(i + 1); up_if.w_strb = 8'hFF;
        up_if.w_last = (i == 3); up_if.w_user = 1'(i);
      end else begin
        up_if.w_valid = 0;
      end
    end
  endtask

  task automatic test_stall();
    @(negedge clk);
    idle();
    dn_if.w_ready = 0;
    checks++; if (up_if.w_ready !== 1) begin failures++; $display("FAIL stall_rdy0 got=%b exp=1", up_if.w_ready); end
    up_if.w_valid = 1; up_if.w_data = 64'h11; up_if.w_strb = 8'h0F; up_if.w_last = 0;
    @(negedge clk);
    checks++; if (dn_if.w_valid !== 1 || dn_if.w_data !== 64'h11) begin failures++; $display("FAIL stall_out1 got v=%b d=%h exp v=1 d=11", dn_if.w_valid, dn_if.w_data); end
    checks++; if (up_if.w_ready !== 1) begin failures++; $display("FAIL stall_rdy1 got=%b exp=1", up_if.w_ready); end
    up_if.w_data = 64'h22; up_if.w_strb = 8'hF0;
    @(negedge clk);
    checks++; if (up_if.w_ready !== 0) begin failures++; $display("FAIL stall_rdy2 got=%b exp=0", up_if.w_ready); end
    checks++; if (dn_if.w_valid !== 1 || dn_if.w_data !== 64'h11 || dn_if.w_strb !== 8'h0F) begin failures++; $display("FAIL stall_hold1 got v=%b d=%h s=%h exp v=1 d=11 s=0f", dn_if.w_valid, dn_if.w_data, dn_if.w_strb); end
    up_if.w_data = 64'h33; up_if.w_strb = 8'hAA; up_if.w_last = 1;
    @(negedge clk);
    checks++; if (up_if.w_ready !== 0) begin failures++; $display("FAIL stall_rdy3 got=%b exp=0", up_if.w_ready); end
    checks++; if (dn_if.w_valid !== 1 || dn_if.w_data !== 64'h11 || dn_if.w_strb !== 8'h0F) begin failures++; $display("FAIL stall_hold2 got v=%b d=%h s=%h exp v=1 d=11 s=0f", dn_if.w_valid, dn_if.w_data, dn_if.w_strb); end
    dn_if.w_ready = 1;
    @(negedge clk);
    checks++; if (dn_if.w_valid !== 1 || dn_if.w_data !== 64'h22 || dn_if.w_strb !== 8'hF0 || dn_if.w_last !== 0) begin failures++; $display("FAIL stall_out2 got v=%b d=%h s=%h l=%b exp v=1 d=22 s=f0 l=0", dn_if.w_valid, dn_if.w_data, dn_if.w_strb, dn_if.w_last); end
    checks++; if (up_if.w_ready !== 1) begin failures++; $display("FAIL stall_rdy_back got=%b exp=1", up_if.w_ready); end
    @(negedge clk);
    up_if.w_valid = 0;
    checks++; if (dn_if.w_valid !== 1 || dn_if.w_data !== 64'h33 || dn_if.w_strb !== 8'hAA || dn_if.w_last !== 1) begin failures++; $display("FAIL stall_out3 got v=%b d=%h s=%h l=%b exp v=1 d=33 s=aa l=1", dn_if.w_valid, dn_if.w_data, dn_if.w_strb, dn_if.w_last); end
    @(negedge clk);
    checks++; if (dn_if.w_valid !== 0) begin failures++; $display("FAIL stall_drained got=%b exp=0", dn_if.w_valid); end
  endtask

  task automatic test_r_toggle();
    int tx = 0;
    int rx = 0;
    bit src_fire = 0;
    logic [75:0] got, exp;
    @(negedge clk);
    idle();
    for (int cyc = 0; cyc < 80 && rx < 8; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (src_fire) tx++;
      if (tx < 8) begin
        dn_if.r_valid = 1; dn_if.r_id = 8'h03; dn_if.r_resp = 2'b00;
        dn_if.r_data = 64'(256 + tx); dn_if.r_last = (tx == 7); dn_if.r_user = 1'(tx);
      end else begin
        dn_if.r_valid = 0;
      end
      src_fire = dn_if.r_valid && dn_if.r_ready;
      up_if.r_ready = cyc[0];
      if (up_if.r_valid === 1 && up_if.r_ready === 1) begin
        got = {up_if.r_id, up_if.r_data, up_if.r_resp, up_if.r_last, up_if.r_user};
        exp = {8'h03, 64'(256 + rx), 2'b00, (rx == 7), 1'(rx)};
        checks++; if (got !== exp) begin failures++; $display("FAIL r_beat%0d got=%h exp=%h", rx, got, exp); end
        rx++;
      end
    end
    checks++; if (rx != 8) begin failures++; $display("FAIL r_timeout got=%0d beats exp=8", rx); end
    @(negedge clk);
    dn_if.r_valid = 0;
    up_if.r_ready = 1;
    checks++; if (up_if.r_valid !== 0) begin failures++; $display("FAIL r_extra got=%b exp=0", up_if.r_valid); end
  endtask

  task automatic test_reset_mid();
    logic [4:0] v, r;
    @(negedge clk);
    idle();
    dn_if.aw_ready = 0; up_if.b_ready = 0;
    up_if.aw_valid = 1; up_if.aw_id = 8'h01; up_if.aw_addr = 48'h100;
    dn_if.b_valid = 1; dn_if.b_id = 8'h07; dn_if.b_resp = 2'b10;
    @(negedge clk);
    up_if.aw_id = 8'h02; dn_if.b_id = 8'h08;
    @(negedge clk);
    up_if.aw_valid = 0; dn_if.b_valid = 0;
    checks++; if ({up_if.aw_ready, dn_if.b_ready} !== 2'b00) begin failures++; $display("FAIL mid_full got=%b exp=00", {up_if.aw_ready, dn_if.b_ready}); end
    checks++; if (dn_if.aw_valid !== 1 || dn_if.aw_id !== 8'h01 || up_if.b_valid !== 1 || up_if.b_id !== 8'h07) begin failures++; $display("FAIL mid_held got aw=%b/%h b=%b/%h exp 1/01 1/07", dn_if.aw_valid, dn_if.aw_id, up_if.b_valid, up_if.b_id); end
    #2 rstn = 0;
    #1;
    v = {dn_if.aw_valid, dn_if.ar_valid, dn_if.w_valid, up_if.r_valid, up_if.b_valid};
    r = {up_if.aw_ready, up_if.ar_ready, up_if.w_ready, dn_if.r_ready, dn_if.b_ready};
    checks++; if (v !== 5'b0) begin failures++; $display("FAIL mid_async_valids got=%b exp=00000", v); end
    checks++; if (r !== 5'b0) begin failures++; $display("FAIL mid_async_readies got=%b exp=00000", r); end
    dn_if.aw_ready = 1; up_if.b_ready = 1;
    @(negedge clk);
    rstn = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      v = {dn_if.aw_valid, dn_if.ar_valid, dn_if.w_valid, up_if.r_valid, up_if.b_valid};
      checks++; if (v !== 5'b0) begin failures++; $display("FAIL mid_stale%0d got=%b exp=00000", k, v); end
      if (k == 0) begin
        r = {up_if.aw_ready, up_if.ar_ready, up_if.w_ready, dn_if.r_ready, dn_if.b_ready};
        checks++; if (r !== 5'b11111) begin failures++; $display("FAIL mid_readies got=%b exp=11111", r); end
      end
    end
  endtask

  task automatic test_independence();
    @(negedge clk);
    idle();
    dn_if.ar_ready = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      if (i >= 1 && i <= 6) begin
        checks++;
        if (dn_if.aw_valid !== 1 || dn_if.aw_addr !== 48'(i * 16) || dn_if.w_valid !== 1 || dn_if.w_data !== 64'(i)) begin
          failures++;
          $display("FAIL indep_beat%0d got aw=%b/%h w=%b/%h exp aw=1/%h w=1/%h", i, dn_if.aw_valid,
                   dn_if.aw_addr, dn_if.w_valid, dn_if.w_data, 48'(i * 16), 64'(i));
        end
      end else begin
        checks++; if ({dn_if.aw_valid, dn_if.w_valid} !== 2'b00) begin failures++; $display("FAIL indep_idle%0d got=%b exp=00", i, {dn_if.aw_valid, dn_if.w_valid}); end
      end
      if (i < 6) begin
        checks++; if ({up_if.aw_ready, up_if.w_ready} !== 2'b11) begin failures++; $display("FAIL indep_ready%0d got=%b exp=11", i, {up_if.aw_ready, up_if.w_ready}); end
        up_if.aw_valid = 1; up_if.aw_addr = 48'((i + 1) * 16); up_if.aw_id = 8'(i + 1);
        up_if.w_valid = 1; up_if.w_data = 64'(i + 1); up_if.w_last = 1; up_if.w_strb = 8'hFF;
      end else begin
        up_if.aw_valid = 0; up_if.w_valid = 0;
      end
      if (i < 2) begin
        up_if.ar_valid = 1; up_if.ar_addr = 48'(160 + i); up_if.ar_id = 8'(i);
      end else begin
        up_if.ar_valid = 0;
      end
    end
    checks++; if (up_if.ar_ready !== 0) begin failures++; $display("FAIL indep_ar_ready got=%b exp=0", up_if.ar_ready); end
    checks++; if (dn_if.ar_valid !== 1 || dn_if.ar_addr !== 48'hA0) begin failures++; $display("FAIL indep_ar_hold got=%b/%h exp=1/a0", dn_if.ar_valid, dn_if.ar_addr); end
    dn_if.ar_ready = 1;
    @(negedge clk);
    checks++; if (dn_if.ar_valid !== 1 || dn_if.ar_addr !== 48'hA1) begin failures++; $display("FAIL indep_ar_drain got=%b/%h exp=1/a1", dn_if.ar_valid, dn_if.ar_addr); end
    @(negedge clk);
    checks++; if (dn_if.ar_valid !== 0) begin failures++; $display("FAIL indep_ar_empty got=%b exp=0", dn_if.ar_valid); end
  endtask

  initial begin
    test_reset();
    test_single_aw();
    test_w_burst();
    test_stall();
    test_r_toggle();
    test_reset_mid();
    test_independence();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
